// File: rtl/mac_width_fifo.sv
// Purpose: single-clock FWFT FIFO that converts between write and read bus widths, LS unit first.
// Latency: a write accepted at edge N is readable (data_out/data_out_valid/level) right after edge N.
// Backpressure: data_in_ready/data_out_valid come from registered level only; refused requests raise 1-cycle error pulses.
module mac_width_fifo #(
    parameter int DATA_IN_WIDTH     = 32,
    parameter int DATA_OUT_WIDTH    = 4,
    parameter int FIFO_DEPTH        = 16,
    parameter int ALMOST_FULL_LEVEL = 12
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic                              flush,
    input  logic [DATA_IN_WIDTH-1:0]          data_in,
    input  logic                              data_in_enable,
    output logic                              data_in_ready,
    output logic [DATA_OUT_WIDTH-1:0]         data_out,
    input  logic                              data_out_enable,
    output logic                              data_out_valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   level,
    output logic                              almost_full,
    output logic                              overflow,
    output logic                              underflow
);

    // Narrow unit width and how many units each side moves per transfer.
    localparam int NW = (DATA_IN_WIDTH < DATA_OUT_WIDTH) ? DATA_IN_WIDTH : DATA_OUT_WIDTH;
    localparam int RI = DATA_IN_WIDTH / NW;
    localparam int RO = DATA_OUT_WIDTH / NW;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);

    logic [NW-1:0] mem_q [FIFO_DEPTH];
    logic [NW-1:0] mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic          wr_acc;
    logic          rd_acc;

    // Flags are pure functions of the registered level; no same-cycle pop feeds ready.
    always_comb begin
        data_in_ready  = (level_q <= LW'(FIFO_DEPTH - RI));
        data_out_valid = (level_q >= LW'(RO));
        almost_full    = (level_q >= LW'(ALMOST_FULL_LEVEL));
        level          = level_q;
        overflow       = overflow_q;
        underflow      = underflow_q;
        wr_acc         = data_in_enable  && data_in_ready  && !flush;
        rd_acc         = data_out_enable && data_out_valid && !flush;
    end

    // Pointer, level and error-pulse next state; flush overrides any request.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + PW'(RI);
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + PW'(RO);
            end
            level_d     = level_q + (wr_acc ? LW'(RI) : LW'(0)) - (rd_acc ? LW'(RO) : LW'(0));
            overflow_d  = data_in_enable  && !data_in_ready;
            underflow_d = data_out_enable && !data_out_valid;
        end
    end

    // Scatter an accepted write word into consecutive units starting at wr_ptr.
    always_comb begin
        logic [PW-1:0] wr_idx;
        wr_idx = '0;
        mem_d  = mem_q;
        if (wr_acc) begin
            for (int i = 0; i < RI; i++) begin
                wr_idx        = wr_ptr_q + PW'(i);
                mem_d[wr_idx] = data_in[i*NW +: NW];
            end
        end
    end

    // Gather RO units from rd_ptr onward; output is zero whenever a full word is not stored.
    always_comb begin
        logic [PW-1:0] rd_idx;
        rd_idx   = '0;
        data_out = '0;
        if (data_out_valid) begin
            for (int j = 0; j < RO; j++) begin
                rd_idx                = rd_ptr_q + PW'(j);
                data_out[j*NW +: NW]  = mem_q[rd_idx];
            end
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array carries no reset; stale contents are masked by level.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_mac_width_fifo.sv
// Bench for mac_width_fifo: instance 0 downsizes 32->4, instance 1 upsizes 4->32.
// A nibble-queue reference model per instance is filled on accepted writes and drained by the monitor.
module tb_mac_width_fifo;

    logic        clock;
    logic        reset_n;
    logic        flush [2];
    logic        wen   [2];
    logic        ren   [2];
    logic [31:0] din   [2];
    logic [31:0] dout  [2];
    logic        vld   [2];
    logic        rdy   [2];
    logic        af    [2];
    logic        ovf   [2];
    logic        udf   [2];
    logic [4:0]  lvl   [2];

    int n_chk;
    int n_fail;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int IW = (g == 0) ? 32 : 4;
        localparam int OW = (g == 0) ? 4 : 32;
        localparam int RI = IW / 4;
        localparam int RO = OW / 4;

        logic [IW-1:0] d_in;
        logic [OW-1:0] d_out;
        logic [4:0]    lvl_l;
        logic          vld_l, rdy_l, af_l, ovf_l, udf_l;

        assign d_in    = din[g][IW-1:0];
        assign dout[g] = 32'(d_out);
        assign lvl[g]  = lvl_l;
        assign vld[g]  = vld_l;
        assign rdy[g]  = rdy_l;
        assign af[g]   = af_l;
        assign ovf[g]  = ovf_l;
        assign udf[g]  = udf_l;

        mac_width_fifo #(
            .DATA_IN_WIDTH(IW),
            .DATA_OUT_WIDTH(OW),
            .FIFO_DEPTH(16),
            .ALMOST_FULL_LEVEL(12)
        ) u_dut (
            .clock(clock),
            .reset_n(reset_n),
            .flush(flush[g]),
            .data_in(d_in),
            .data_in_enable(wen[g]),
            .data_in_ready(rdy_l),
            .data_out(d_out),
            .data_out_enable(ren[g]),
            .data_out_valid(vld_l),
            .level(lvl_l),
            .almost_full(af_l),
            .overflow(ovf_l),
            .underflow(udf_l)
        );

        // Reference: queue of stored nibbles, oldest first.
        logic [3:0] mq[$];
        bit         e_ovf;
        bit         e_udf;

        // Monitor: compare outputs against the model, then apply this cycle's requests to it.
        always @(negedge clock) begin
            int          lv;
            bit          can_w;
            bit          can_r;
            logic [31:0] e_dout;
            if (!reset_n) begin
                mq.delete();
                e_ovf = 1'b0;
                e_udf = 1'b0;
            end
            lv     = mq.size();
            can_w  = (16 - lv) >= RI;
            can_r  = lv >= RO;
            e_dout = '0;
            if (can_r) begin
                for (int j = 0; j < RO; j++) e_dout[j*4 +: 4] = mq[j];
            end
            chk($sformatf("i%0d_level", g), 32'(lvl_l), 32'(lv));
            chk($sformatf("i%0d_valid", g), 32'(vld_l), 32'(can_r));
            chk($sformatf("i%0d_ready", g), 32'(rdy_l), 32'(can_w));
            chk($sformatf("i%0d_afull", g), 32'(af_l), 32'(lv >= 12));
            chk($sformatf("i%0d_ovf", g), 32'(ovf_l), 32'(e_ovf));
            chk($sformatf("i%0d_udf", g), 32'(udf_l), 32'(e_udf));
            chk($sformatf("i%0d_dout", g), 32'(d_out), e_dout);
            if (reset_n) begin
                if (flush[g]) begin
                    mq.delete();
                    e_ovf = 1'b0;
                    e_udf = 1'b0;
                end else begin
                    e_ovf = wen[g] && !can_w;
                    e_udf = ren[g] && !can_r;
                    if (ren[g] && can_r) begin
                        for (int j = 0; j < RO; j++) void'(mq.pop_front());
                    end
                    if (wen[g] && can_w) begin
                        for (int i = 0; i < RI; i++) mq.push_back(din[g][i*4 +: 4]);
                    end
                end
            end
        end
    end

    initial begin
        logic [3:0] nib;
        n_chk   = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        for (int g = 0; g < 2; g++) begin
            flush[g] = 1'b0;
            wen[g]   = 1'b0;
            ren[g]   = 1'b0;
            din[g]   = '0;
        end
        repeat (2) tick();
        chk("reset_ready", 32'(rdy[0]), 32'd1);
        reset_n = 1'b1;
        tick();

        // Downsize: one word out as eight nibbles, LS first.
        wen[0] = 1'b1;
        din[0] = 32'h87654321;
        tick();
        wen[0] = 1'b0;
        chk("t1_level", 32'(lvl[0]), 32'd8);
        ren[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            chk("t1_nibble", dout[0], 32'(k));
            tick();
        end
        ren[0] = 1'b0;
        chk("t1_empty_valid", 32'(vld[0]), 32'd0);

        // Full: two words fill, third is refused with an overflow pulse.
        wen[0] = 1'b1;
        din[0] = 32'hA9876543;
        tick();
        din[0] = 32'h1FEDCBA0;
        tick();
        chk("t3_level", 32'(lvl[0]), 32'd16);
        chk("t3_ready", 32'(rdy[0]), 32'd0);
        chk("t3_afull", 32'(af[0]), 32'd1);
        din[0] = 32'hDEADBEEF;
        tick();
        wen[0] = 1'b0;
        chk("t3_ovf", 32'(ovf[0]), 32'd1);
        chk("t3_level_kept", 32'(lvl[0]), 32'd16);
        tick();
        chk("t3_ovf_once", 32'(ovf[0]), 32'd0);
        ren[0] = 1'b1;
        repeat (16) tick();
        ren[0] = 1'b0;

        // Wrap: replicated-nibble words, pointers cycle through the array.
        for (int k = 0; k < 5; k++) begin
            nib    = 4'(k);
            wen[0] = 1'b1;
            din[0] = {8{nib}};
            tick();
            wen[0] = 1'b0;
            ren[0] = 1'b1;
            for (int j = 0; j < 8; j++) begin
                chk("t4_wrap_nibble", dout[0], 32'(nib));
                tick();
            end
            ren[0] = 1'b0;
        end

        // Concurrent push/pop, then flush racing a refused push.
        wen[0] = 1'b1;
        din[0] = $urandom;
        tick();
        din[0] = $urandom;
        ren[0] = 1'b1;
        tick();
        wen[0] = 1'b0;
        ren[0] = 1'b0;
        chk("t5_level15", 32'(lvl[0]), 32'd15);
        flush[0] = 1'b1;
        wen[0]   = 1'b1;
        tick();
        flush[0] = 1'b0;
        wen[0]   = 1'b0;
        chk("t5_flush_level", 32'(lvl[0]), 32'd0);
        chk("t5_flush_valid", 32'(vld[0]), 32'd0);
        tick();
        chk("t5_no_ovf", 32'(ovf[0]), 32'd0);

        // Underflow pulse, then reset dropped mid-stream.
        ren[0] = 1'b1;
        tick();
        ren[0] = 1'b0;
        chk("t6_udf", 32'(udf[0]), 32'd1);
        chk("t6_level", 32'(lvl[0]), 32'd0);
        tick();
        chk("t6_udf_once", 32'(udf[0]), 32'd0);
        wen[0] = 1'b1;
        din[0] = $urandom;
        tick();
        wen[0] = 1'b0;
        ren[0] = 1'b1;
        tick();
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_level", 32'(lvl[0]), 32'd0);
        chk("t6_rst_valid", 32'(vld[0]), 32'd0);
        chk("t6_rst_ready", 32'(rdy[0]), 32'd1);
        chk("t6_rst_dout", dout[0], 32'd0);
        ren[0] = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();

        // Upsize: eight nibbles assemble one 32-bit word.
        wen[1] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            din[1] = 32'(k);
            tick();
            if (k < 8) chk("t2_partial_valid", 32'(vld[1]), 32'd0);
        end
        wen[1] = 1'b0;
        chk("t2_valid", 32'(vld[1]), 32'd1);
        chk("t2_word", dout[1], 32'h87654321);
        ren[1] = 1'b1;
        tick();
        ren[1] = 1'b0;
        chk("t2_drained", 32'(lvl[1]), 32'd0);

        // Random traffic on both instances, with one reset in the middle.
        for (int c = 0; c < 1500; c++) begin
            for (int g = 0; g < 2; g++) begin
                wen[g]   = ($urandom_range(0, 2) != 0);
                ren[g]   = ($urandom_range(0, 2) != 0);
                flush[g] = ($urandom_range(0, 60) == 0);
                din[g]   = $urandom;
            end
            if (c == 700) begin
                @(posedge clock);
                #3;
                reset_n = 1'b0;
                tick();
                reset_n = 1'b1;
            end else begin
                tick();
            end
        end
        for (int g = 0; g < 2; g++) begin
            wen[g]   = 1'b0;
            ren[g]   = 1'b0;
            flush[g] = 1'b0;
        end
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
